// File: rtl/trees_stream_ctrl.sv
`timescale 1ns/1ps
// trees_stream_ctrl: upstream sequencer for the trees ensemble engine.
// It loads the tree memory from the input stream, then for each sample writes
// the features, starts the engine, waits for done and returns the prediction.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | waiting for a command; cmd_ready=1
// LOAD_TREES  | one tree node word per beat into the engine tree memory
// LOAD_FEAT   | two features per beat into the engine feature registers
// FLUSH       | lets the last feature write land before the engine starts
// START       | one-cycle start pulse
// WAIT_DONE   | engine running; features are frozen
// RESULT      | prediction held on the result port until accepted
// FINISH      | one-cycle cmd_done pulse, then IDLE
module trees_stream_ctrl #(
  parameter int N_TREES          = 16,
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_load_model,
  input  logic [15:0]                         cmd_n_samples,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [63:0]                         in_data,
  output logic                                load_trees,
  output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
  output logic [$clog2(N_TREES)-1:0]          n_tree,
  output logic [63:0]                         tree_nodes,
  output logic                                load_features,
  output logic [31:0]                         n_feature,
  output logic [63:0]                         features2,
  output logic                                start,
  input  logic                                done,
  input  logic [31:0]                         prediction,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [31:0]                         res_data,
  output logic                                busy,
  output logic                                cmd_done
);

  localparam int NW  = $clog2(N_NODE_AND_LEAFS);
  localparam int TW  = $clog2(N_TREES);
  // Counts feature beats (pairs); one spare bit keeps the width >= 1 for N_FEATURE=2.
  localparam int FCW = $clog2(N_FEATURE);

  localparam logic [NW-1:0]  NODE_LAST = NW'(N_NODE_AND_LEAFS - 1);
  localparam logic [TW-1:0]  TREE_LAST = TW'(N_TREES - 1);
  localparam logic [FCW-1:0] FEAT_LAST = FCW'(N_FEATURE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_TREES,
    S_LOAD_FEAT,
    S_FLUSH,
    S_START,
    S_WAIT_DONE,
    S_RESULT,
    S_FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    n_samples_q, n_samples_d;
  logic [15:0]    sample_cnt_q, sample_cnt_d;
  logic [NW-1:0]  node_cnt_q, node_cnt_d;
  logic [TW-1:0]  tree_cnt_q, tree_cnt_d;
  logic [FCW-1:0] feat_cnt_q, feat_cnt_d;

  logic           load_trees_q, load_trees_d;
  logic [NW-1:0]  n_node_q, n_node_d;
  logic [TW-1:0]  n_tree_q, n_tree_d;
  logic [63:0]    tree_nodes_q, tree_nodes_d;
  logic           load_features_q, load_features_d;
  logic [31:0]    n_feature_q, n_feature_d;
  logic [63:0]    features2_q, features2_d;
  logic           res_valid_q, res_valid_d;
  logic [31:0]    res_data_q, res_data_d;

  logic           beat;

  assign beat = in_valid && in_ready;

  // Next-state, counter and registered-output logic; Moore handshake outputs.
  always_comb begin
    state_d         = state_q;
    n_samples_d     = n_samples_q;
    sample_cnt_d    = sample_cnt_q;
    node_cnt_d      = node_cnt_q;
    tree_cnt_d      = tree_cnt_q;
    feat_cnt_d      = feat_cnt_q;
    load_trees_d    = 1'b0;
    n_node_d        = '0;
    n_tree_d        = '0;
    tree_nodes_d    = '0;
    load_features_d = 1'b0;
    n_feature_d     = '0;
    features2_d     = '0;
    res_valid_d     = res_valid_q;
    res_data_d      = res_data_q;
    cmd_ready       = 1'b0;
    in_ready        = 1'b0;
    start           = 1'b0;
    cmd_done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready    = 1'b1;
        sample_cnt_d = '0;
        node_cnt_d   = '0;
        tree_cnt_d   = '0;
        feat_cnt_d   = '0;
        if (cmd_valid) begin
          n_samples_d = cmd_n_samples;
          if (cmd_load_model)           state_d = S_LOAD_TREES;
          else if (cmd_n_samples != '0) state_d = S_LOAD_FEAT;
          else                          state_d = S_FINISH;
        end
      end

      S_LOAD_TREES: begin
        in_ready = 1'b1;
        if (beat) begin
          load_trees_d = 1'b1;
          n_node_d     = node_cnt_q;
          n_tree_d     = tree_cnt_q;
          tree_nodes_d = in_data;
          if (node_cnt_q == NODE_LAST) begin
            node_cnt_d = '0;
            if (tree_cnt_q == TREE_LAST) begin
              tree_cnt_d = '0;
              state_d    = (n_samples_q != '0) ? S_LOAD_FEAT : S_FINISH;
            end else begin
              tree_cnt_d = tree_cnt_q + TW'(1);
            end
          end else begin
            node_cnt_d = node_cnt_q + NW'(1);
          end
        end
      end

      S_LOAD_FEAT: begin
        in_ready = 1'b1;
        if (beat) begin
          load_features_d = 1'b1;
          n_feature_d     = {{(31 - FCW){1'b0}}, feat_cnt_q, 1'b0};
          features2_d     = in_data;
          if (feat_cnt_q == FEAT_LAST) begin
            feat_cnt_d = '0;
            state_d    = S_FLUSH;
          end else begin
            feat_cnt_d = feat_cnt_q + FCW'(1);
          end
        end
      end

      S_FLUSH: state_d = S_START;

      S_START: begin
        start   = 1'b1;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (done) begin
          res_valid_d = 1'b1;
          res_data_d  = prediction;
          state_d     = S_RESULT;
        end
      end

      S_RESULT: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          res_data_d   = '0;
          sample_cnt_d = sample_cnt_q + 16'd1;
          state_d      = ((sample_cnt_q + 16'd1) < n_samples_q) ? S_LOAD_FEAT : S_FINISH;
        end
      end

      S_FINISH: begin
        cmd_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and engine-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      n_samples_q     <= '0;
      sample_cnt_q    <= '0;
      node_cnt_q      <= '0;
      tree_cnt_q      <= '0;
      feat_cnt_q      <= '0;
      load_trees_q    <= 1'b0;
      n_node_q        <= '0;
      n_tree_q        <= '0;
      tree_nodes_q    <= '0;
      load_features_q <= 1'b0;
      n_feature_q     <= '0;
      features2_q     <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      n_samples_q     <= n_samples_d;
      sample_cnt_q    <= sample_cnt_d;
      node_cnt_q      <= node_cnt_d;
      tree_cnt_q      <= tree_cnt_d;
      feat_cnt_q      <= feat_cnt_d;
      load_trees_q    <= load_trees_d;
      n_node_q        <= n_node_d;
      n_tree_q        <= n_tree_d;
      tree_nodes_q    <= tree_nodes_d;
      load_features_q <= load_features_d;
      n_feature_q     <= n_feature_d;
      features2_q     <= features2_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
    end
  end

  assign load_trees    = load_trees_q;
  assign n_node        = n_node_q;
  assign n_tree        = n_tree_q;
  assign tree_nodes    = tree_nodes_q;
  assign load_features = load_features_q;
  assign n_feature     = n_feature_q;
  assign features2     = features2_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_trees_stream_ctrl.sv
`timescale 1ns/1ps
// Bench for trees_stream_ctrl with a small configuration (2 trees, 4 nodes,
// 4 features). Stimulus pushes expected writes/results into queues; a monitor
// pops and compares whenever the DUT presents a write, start, result or done.
module tb_trees_stream_ctrl;
  localparam int NT = 2;
  localparam int NN = 4;
  localparam int NF = 4;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_load_model;
  logic [15:0] cmd_n_samples;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        load_trees;
  logic [1:0]  n_node;
  logic [0:0]  n_tree;
  logic [63:0] tree_nodes;
  logic        load_features;
  logic [31:0] n_feature;
  logic [63:0] features2;
  logic        start, done;
  logic [31:0] prediction;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        busy, cmd_done;

  trees_stream_ctrl #(.N_TREES(NT), .N_NODE_AND_LEAFS(NN), .N_FEATURE(NF)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load_model(cmd_load_model), .cmd_n_samples(cmd_n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load_trees(load_trees), .n_node(n_node), .n_tree(n_tree), .tree_nodes(tree_nodes),
    .load_features(load_features), .n_feature(n_feature), .features2(features2),
    .start(start), .done(done), .prediction(prediction),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .cmd_done(cmd_done)
  );

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [63:0] d;
  } exp_wr_t;

  exp_wr_t     exp_tree[$];
  exp_wr_t     exp_feat[$];
  int          exp_start[$];
  int          exp_done[$];
  logic [31:0] exp_res[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_wr_t     e;
    int          c;
    logic [31:0] r;
    logic        prev_hold;
    logic [31:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (load_trees) begin
        if (exp_tree.size() == 0) unexpected("load_trees");
        else begin
          e = exp_tree.pop_front();
          chk("tree_cycle", 64'(cyc), 64'(e.c));
          chk("tree_index", 64'({n_tree, n_node}), 64'(e.a));
          chk("tree_data", tree_nodes, e.d);
        end
      end
      if (load_features) begin
        if (exp_feat.size() == 0) unexpected("load_features");
        else begin
          e = exp_feat.pop_front();
          chk("feat_cycle", 64'(cyc), 64'(e.c));
          chk("feat_index", 64'(n_feature), 64'(e.a));
          chk("feat_data", features2, e.d);
        end
      end
      if (start) begin
        if (exp_start.size() == 0) unexpected("start");
        else begin
          c = exp_start.pop_front();
          chk("start_cycle", 64'(cyc), 64'(c));
          chk("start_no_feat_write", 64'(load_features), 64'd0);
        end
      end
      if (prev_hold) begin
        chk("res_valid_held", 64'(res_valid), 64'd1);
        chk("res_data_stable", 64'(res_data), 64'(prev_data));
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) unexpected("result");
        else begin
          r = exp_res.pop_front();
          chk("res_data", 64'(res_data), 64'(r));
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      if (cmd_done) begin
        if (exp_done.size() == 0) unexpected("cmd_done");
        else begin
          c = exp_done.pop_front();
          chk("cmd_done_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  endtask

  task automatic issue_cmd(input logic lm, input logic [15:0] ns);
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) unexpected("cmd_ready_timeout");
    cmd_valid      = 1'b1;
    cmd_load_model = lm;
    cmd_n_samples  = ns;
    tick();
    cmd_valid      = 1'b0;
    if (!lm && ns == 16'd0) exp_done.push_back(cyc);
  endtask

  task automatic send_beat(input logic [63:0] d, input bit is_tree, input logic [31:0] a);
    bit ok;
    exp_wr_t e;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin ok = 1; tick(); break; end
      tick();
    end
    if (!ok) unexpected("in_ready_timeout");
    else begin
      e.c = cyc;
      e.a = a;
      e.d = d;
      if (is_tree) exp_tree.push_back(e);
      else         exp_feat.push_back(e);
    end
  endtask

  task automatic load_model_beats(input bit last);
    for (int t = 0; t < NT; t++)
      for (int n = 0; n < NN; n++)
        send_beat(64'hA5A5_0000_0000_0000 | 64'(t * 16 + n), 1'b1, 32'((t << 2) | n));
    in_valid = 1'b0;
    if (last) exp_done.push_back(cyc);
  endtask

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (start) begin ok = 1; break; end
      tick();
    end
    if (!ok) unexpected("start_timeout");
  endtask

  task automatic feed_features(input logic [63:0] f0, input logic [63:0] f1, input int gap);
    send_beat(f0, 1'b0, 32'd0);
    in_valid = 1'b0;
    repeat (gap) tick();
    send_beat(f1, 1'b0, 32'd2);
    in_valid = 1'b0;
    exp_start.push_back(cyc + 1);
  endtask

  task automatic run_sample(input logic [63:0] f0, input logic [63:0] f1, input logic [31:0] pred,
                            input int gap, input int rdelay, input bit early, input bit last);
    bit ok;
    feed_features(f0, f1, gap);
    wait_start();
    if (early) res_ready = 1'b1;
    tick();
    chk("wait_in_ready", 64'(in_ready), 64'd0);
    chk("wait_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    tick();
    done       = 1'b1;
    prediction = pred;
    exp_res.push_back(pred);
    tick();
    done       = 1'b0;
    prediction = '0;
    repeat (rdelay) tick();
    res_ready = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (res_valid) begin ok = 1; tick(); break; end
      tick();
    end
    if (!ok) unexpected("res_valid_timeout");
    res_ready = 1'b0;
    if (last) exp_done.push_back(cyc);
  endtask

  task automatic stimulus();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load_model = 1'b0; cmd_n_samples = '0;
    in_valid = 1'b0; in_data = '0; done = 1'b0; prediction = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", 64'({load_trees, load_features, start, res_valid, cmd_done}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Model load only, back-to-back beats.
    issue_cmd(1'b1, 16'd0);
    load_model_beats(1'b1);
    tick();
    tick();
    chk("busy_after_load", 64'(busy), 64'd0);

    // One sample, in_valid gaps, result held for three cycles.
    issue_cmd(1'b0, 16'd1);
    run_sample(64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003, 32'd5, 2, 3, 1'b0, 1'b1);
    tick();
    tick();

    // Model load followed by three samples.
    issue_cmd(1'b1, 16'd3);
    load_model_beats(1'b0);
    run_sample(64'h0000_000C_0000_000B, 64'h0000_000E_0000_000D, 32'd7, 0, 0, 1'b0, 1'b0);
    run_sample(64'h0000_0016_0000_0015, 64'h0000_0018_0000_0017, 32'd1, 1, 0, 1'b1, 1'b0);
    run_sample(64'h0000_0020_0000_001F, 64'h0000_0022_0000_0021, 32'd3, 0, 1, 1'b0, 1'b1);
    tick();
    tick();

    // No model, no samples: completes right after accept.
    issue_cmd(1'b0, 16'd0);
    tick();
    tick();
    chk("busy_after_empty", 64'(busy), 64'd0);

    // Asynchronous reset while the engine is running.
    issue_cmd(1'b0, 16'd1);
    feed_features(64'h1111, 64'h2222, 0);
    wait_start();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_outs", 64'({load_trees, load_features, start, res_valid, cmd_done}), 64'd0);
    chk("arst_data", 64'(res_data) | 64'(n_feature) | features2 | tree_nodes, 64'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    tick();
    done       = 1'b1;
    prediction = 32'hDEAD_BEEF;
    tick();
    done       = 1'b0;
    prediction = '0;
    repeat (3) tick();
    chk("late_done_res_valid", 64'(res_valid), 64'd0);
    chk("late_done_busy", 64'(busy), 64'd0);

    chk("left_tree", 64'(exp_tree.size()), 64'd0);
    chk("left_feat", 64'(exp_feat.size()), 64'd0);
    chk("left_start", 64'(exp_start.size()), 64'd0);
    chk("left_res", 64'(exp_res.size()), 64'd0);
    chk("left_done", 64'(exp_done.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        repeat (20000) @(posedge clk);
        unexpected("watchdog");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
